// File: rtl/branch_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_ctrl_if
// Groups the signals around the branch sequencing controller into one bundle:
//   - decode handshake : br_valid/br_ready, br_kind, br_funct3, br_pc, br_imm
//   - operands         : rs1_data, rs2_data, op_hazard
//   - comparator       : cmp_un, cmp_rr1, cmp_rr2 out; cmp_beq, cmp_blt back
//   - resolution       : resolve_done, redirect, redirect_pc, flush,
//                        link_we, link_data, illegal, taken_cnt
// Modports:
//   slave  - the controller (branch_ctrl)
//   master - decode / fetch / comparator side that surrounds it
// -----------------------------------------------------------------------------
interface branch_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            br_valid;
  logic            br_ready;
  logic [1:0]      br_kind;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            op_hazard;
  logic            cmp_un;
  logic [XLEN-1:0] cmp_rr1;
  logic [XLEN-1:0] cmp_rr2;
  logic            cmp_beq;
  logic            cmp_blt;
  logic            resolve_done;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            link_we;
  logic [XLEN-1:0] link_data;
  logic            illegal;
  logic [15:0]     taken_cnt;

  modport slave (
    input  br_valid, br_kind, br_funct3, br_pc, br_imm,
    input  rs1_data, rs2_data, op_hazard, cmp_beq, cmp_blt,
    output br_ready, cmp_un, cmp_rr1, cmp_rr2,
    output resolve_done, redirect, redirect_pc, flush,
    output link_we, link_data, illegal, taken_cnt
  );

  modport master (
    output br_valid, br_kind, br_funct3, br_pc, br_imm,
    output rs1_data, rs2_data, op_hazard, cmp_beq, cmp_blt,
    input  br_ready, cmp_un, cmp_rr1, cmp_rr2,
    input  resolve_done, redirect, redirect_pc, flush,
    input  link_we, link_data, illegal, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Sequences one branch/jump at a time through the external comparator:
// accepts it from decode, waits out operand hazards, presents the registered
// operands to the comparator, resolves taken/not-taken (static not-taken
// prediction, so every taken outcome redirects), then issues redirect, flush,
// link write and a wrapping taken counter.
// Ports:
//   clk    - core clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - branch_ctrl_if.slave (decode handshake, operands, comparator
//            link, resolution outputs)
// Parameters:
//   FLUSH_CYCLES - cycles flush stays high after a taken branch/jump (>=1)
//   XLEN         - datapath width (must match the interface)
// -----------------------------------------------------------------------------
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  branch_ctrl_if.slave bus
);

  localparam int unsigned   CW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, FLUSH} state_t;
  typedef enum logic [1:0] {
    K_BRANCH  = 2'b00,
    K_JAL     = 2'b01,
    K_JALR    = 2'b10,
    K_ILLEGAL = 2'b11
  } kind_t;

  state_t          state, state_nxt;
  kind_t           kind_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] pc_q, imm_q, rr1_q, rr2_q;
  logic [CW-1:0]   flush_cnt;
  logic            resolve_q, redirect_q, link_we_q, illegal_q;
  logic [XLEN-1:0] redirect_pc_q, link_data_q;
  logic [15:0]     taken_q;

  logic            br_ready, accept, load_ops, eval;
  logic            taken, is_illegal, is_link;
  logic [XLEN-1:0] target;

  // rst_n is folded in so decode never sees ready while reset is held.
  assign br_ready = (state == IDLE) & rst_n;
  assign accept   = bus.br_valid & br_ready;
  assign eval     = (state == EVAL);
  // Operands are captured exactly once: at accept if already valid,
  // otherwise in the WAIT cycle where the hazard clears.
  assign load_ops = ((state == IDLE) & accept & ~bus.op_hazard) |
                    ((state == WAIT) & ~bus.op_hazard);
  assign is_link  = (kind_q == K_JAL) | (kind_q == K_JALR);

  // JALR clears bit 0 of the sum; all targets wrap modulo 2^XLEN.
  assign target = (kind_q == K_JALR) ? ((rr1_q + imm_q) & ~XLEN'(1))
                                     : (pc_q + imm_q);

  // Outcome decode from the latched instruction and live comparator results.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    taken      = 1'b0;
    is_illegal = 1'b0;
    case (kind_q)
      K_BRANCH: begin
        case (funct3_q)
          3'b000:         taken = bus.cmp_beq;
          3'b001:         taken = ~bus.cmp_beq;
          3'b100, 3'b110: taken = bus.cmp_blt;
          3'b101, 3'b111: taken = ~bus.cmp_blt;
          default:        is_illegal = 1'b1;
        endcase
      end
      K_JAL, K_JALR: taken = 1'b1;
      default:       is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.op_hazard ? WAIT : EVAL;
      WAIT:    if (!bus.op_hazard) state_nxt = EVAL;
      EVAL:    state_nxt = taken ? FLUSH : IDLE;
      FLUSH:   if (flush_cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q        <= K_BRANCH;
      funct3_q      <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      rr1_q         <= '0;
      rr2_q         <= '0;
      flush_cnt     <= '0;
      resolve_q     <= 1'b0;
      redirect_q    <= 1'b0;
      link_we_q     <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= '0;
      link_data_q   <= '0;
      taken_q       <= '0;
    end else begin
      if (accept) begin
        kind_q   <= kind_t'(bus.br_kind);
        funct3_q <= bus.br_funct3;
        pc_q     <= bus.br_pc;
        imm_q    <= bus.br_imm;
      end
      if (load_ops) begin
        rr1_q <= bus.rs1_data;
        rr2_q <= bus.rs2_data;
      end

      if (eval && taken)       flush_cnt <= FLUSH_LOAD;
      else if (state == FLUSH) flush_cnt <= flush_cnt - CW'(1);

      // Result pulses are one cycle wide: they follow EVAL and drop next.
      resolve_q  <= eval;
      redirect_q <= eval & taken;
      link_we_q  <= eval & is_link;
      illegal_q  <= eval & is_illegal;

      if (eval && taken) begin
        redirect_pc_q <= target;
        taken_q       <= taken_q + 16'd1;
      end
      if (eval && is_link) link_data_q <= pc_q + XLEN'(4);
    end
  end

  assign bus.br_ready     = br_ready;
  assign bus.cmp_un       = funct3_q[2] & funct3_q[1];
  assign bus.cmp_rr1      = rr1_q;
  assign bus.cmp_rr2      = rr2_q;
  assign bus.resolve_done = resolve_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.flush        = (state == FLUSH);
  assign bus.link_we      = link_we_q;
  assign bus.link_data    = link_data_q;
  assign bus.illegal      = illegal_q;
  assign bus.taken_cnt    = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl. A transaction-level reference model
// computes each instruction's outcome (taken, illegal, target, link) with
// plain arithmetic, and the expected cycle timeline follows from the hazard
// length and FLUSH_CYCLES. The bench also plays the external comparator.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;

  localparam int FC   = 2;
  localparam int XLEN = 32;

  logic        clk;
  logic        rst_n;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt;
  logic [31:0] exp_rpc;

  branch_ctrl_if #(.XLEN(XLEN)) u_if ();

  branch_ctrl #(.FLUSH_CYCLES(FC), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // External comparator: combinational from the registered operands.
  assign u_if.cmp_beq = (u_if.cmp_rr1 == u_if.cmp_rr2);
  assign u_if.cmp_blt = u_if.cmp_un ? (u_if.cmp_rr1 < u_if.cmp_rr2)
                                    : ($signed(u_if.cmp_rr1) < $signed(u_if.cmp_rr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Architectural outcome of one branch/jump.
  function automatic void model(input logic [1:0] kind, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                output logic ill, output logic tk,
                                output logic lk, output logic [31:0] tgt);
    ill = 1'b0;
    tk  = 1'b0;
    lk  = 1'b0;
    tgt = pc + imm;
    case (kind)
      2'b00: begin
        case (f3)
          3'b000:  tk = (rs1 == rs2);
          3'b001:  tk = (rs1 != rs2);
          3'b100:  tk = ($signed(rs1) <  $signed(rs2));
          3'b101:  tk = ($signed(rs1) >= $signed(rs2));
          3'b110:  tk = (rs1 <  rs2);
          3'b111:  tk = (rs1 >= rs2);
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin tk = 1'b1; lk = 1'b1; end
      2'b10: begin tk = 1'b1; lk = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic scramble();
    u_if.br_kind   = 2'($urandom);
    u_if.br_funct3 = 3'($urandom);
    u_if.br_pc     = $urandom;
    u_if.br_imm    = $urandom;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!u_if.br_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("ready_wait_timeout", 1'b0, 1'b1);
  endtask

  // Issue one instruction (hazard high for hz cycles starting at accept) and
  // check every output on every cycle until the controller is ready again.
  // hold keeps br_valid asserted with junk while busy.
  task automatic run_br(input logic [1:0] kind, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input int hz, input bit hold);
    logic        ill, tk, lk;
    logic [31:0] tgt;
    int          out_k, last_k;
    model(kind, f3, pc, imm, rs1, rs2, ill, tk, lk, tgt);
    out_k  = 2 + hz;
    last_k = tk ? out_k + FC : out_k;

    wait_ready();
    u_if.br_valid  = 1'b1;
    u_if.br_kind   = kind;
    u_if.br_funct3 = f3;
    u_if.br_pc     = pc;
    u_if.br_imm    = imm;
    u_if.op_hazard = (hz > 0);
    u_if.rs1_data  = (hz > 0) ? $urandom : rs1;
    u_if.rs2_data  = (hz > 0) ? $urandom : rs2;

    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 1)      check("cmp_un", u_if.cmp_un, f3[2] & f3[1]);
      if (k == hz + 1) begin
        check("cmp_rr1", u_if.cmp_rr1, rs1);
        check("cmp_rr2", u_if.cmp_rr2, rs2);
      end
      if (k == out_k && tk) begin
        exp_cnt = exp_cnt + 16'd1;
        exp_rpc = tgt;
      end
      check("resolve_done", u_if.resolve_done, k == out_k);
      check("redirect", u_if.redirect, (k == out_k) && tk);
      check("link_we", u_if.link_we, (k == out_k) && lk);
      check("illegal", u_if.illegal, (k == out_k) && ill);
      check("flush", u_if.flush, tk && (k >= out_k) && (k < out_k + FC));
      check("br_ready", u_if.br_ready, k == last_k);
      if (k == out_k) begin
        check("redirect_pc", u_if.redirect_pc, exp_rpc);
        check("taken_cnt", u_if.taken_cnt, exp_cnt);
        if (lk) check("link_data", u_if.link_data, pc + 32'd4);
      end

      // Inputs for the next edge: junk except the operands on hazard drop.
      scramble();
      u_if.br_valid = (k < last_k) ? (hold ? 1'b1 : 1'($urandom)) : 1'b0;
      if (k < hz) begin
        u_if.op_hazard = 1'b1;
        u_if.rs1_data  = $urandom;
        u_if.rs2_data  = $urandom;
      end else if (k == hz) begin
        u_if.op_hazard = 1'b0;
        u_if.rs1_data  = rs1;
        u_if.rs2_data  = rs2;
      end else begin
        u_if.op_hazard = 1'($urandom);
        u_if.rs1_data  = $urandom;
        u_if.rs2_data  = $urandom;
      end
    end
  endtask

  task automatic check_reset_values();
    check("rst_br_ready", u_if.br_ready, 1'b0);
    check("rst_flush", u_if.flush, 1'b0);
    check("rst_resolve_done", u_if.resolve_done, 1'b0);
    check("rst_redirect", u_if.redirect, 1'b0);
    check("rst_link_we", u_if.link_we, 1'b0);
    check("rst_illegal", u_if.illegal, 1'b0);
    check("rst_cmp_un", u_if.cmp_un, 1'b0);
    check("rst_cmp_rr1", u_if.cmp_rr1, 32'h0);
    check("rst_cmp_rr2", u_if.cmp_rr2, 32'h0);
    check("rst_redirect_pc", u_if.redirect_pc, 32'h0);
    check("rst_link_data", u_if.link_data, 32'h0);
    check("rst_taken_cnt", u_if.taken_cnt, 16'h0);
  endtask

  initial begin
    logic [1:0]  kind;
    logic [31:0] rs1, rs2;
    int          r, hz;

    rst_n          = 1'b0;
    u_if.br_valid  = 1'b0;
    u_if.br_kind   = 2'b00;
    u_if.br_funct3 = 3'b000;
    u_if.br_pc     = '0;
    u_if.br_imm    = '0;
    u_if.rs1_data  = '0;
    u_if.rs2_data  = '0;
    u_if.op_hazard = 1'b0;
    exp_cnt        = '0;
    exp_rpc        = '0;

    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_br(2'b00, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 0, 1'b0);                 // BEQ taken
    run_br(2'b00, 3'b100, 32'h140, 32'h10, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);         // BLT taken
    run_br(2'b00, 3'b110, 32'h180, 32'h10, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);         // BLTU not taken
    run_br(2'b10, 3'b000, 32'h200, 32'h4, 32'h1001, 32'h0, 3, 1'b0);               // JALR, hazard 3
    run_br(2'b01, 3'b011, 32'h400, 32'hFFFF_FFF8, 32'h0, 32'h0, 0, 1'b1);          // JAL backward
    run_br(2'b00, 3'b010, 32'h500, 32'h40, 32'h3, 32'h3, 0, 1'b1);                 // illegal funct3
    run_br(2'b00, 3'b011, 32'h504, 32'h40, 32'h3, 32'h4, 1, 1'b0);                 // illegal funct3
    run_br(2'b11, 3'b000, 32'h508, 32'h40, 32'h3, 32'h3, 0, 1'b1);                 // illegal kind
    run_br(2'b00, 3'b001, 32'h600, 32'h8, 32'h7, 32'h7, 2, 1'b1);                  // BNE not taken

    // Counter wrap and target wrap.
    force dut.taken_q = 16'hFFFF;
    #1 release dut.taken_q;
    exp_cnt = 16'hFFFF;
    check("cnt_preload", u_if.taken_cnt, exp_cnt);
    run_br(2'b00, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h9, 32'h9, 0, 1'b0);

    // Reset in the middle of FLUSH.
    wait_ready();
    u_if.br_valid  = 1'b1;
    u_if.br_kind   = 2'b01;
    u_if.br_funct3 = 3'b000;
    u_if.br_pc     = 32'h300;
    u_if.br_imm    = 32'h40;
    u_if.op_hazard = 1'b0;
    @(negedge clk);                   // EVAL
    @(negedge clk);                   // first FLUSH cycle
    exp_cnt = exp_cnt + 16'd1;
    check("rstf_flush_on", u_if.flush, 1'b1);
    check("rstf_cnt_before", u_if.taken_cnt, exp_cnt);
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    exp_rpc = '0;
    check("rstf_flush_off", u_if.flush, 1'b0);
    check("rstf_cnt_cleared", u_if.taken_cnt, exp_cnt);
    check("rstf_br_ready", u_if.br_ready, 1'b0);
    check("rstf_redirect_pc", u_if.redirect_pc, exp_rpc);
    u_if.br_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstf_ready_after", u_if.br_ready, 1'b1);
    check("rstf_no_pulse", u_if.resolve_done, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r    = $urandom_range(0, 9);
      kind = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      rs1  = $urandom;
      rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      if ($urandom_range(0, 3) == 0) rs2 = rs2 ^ 32'h8000_0000;
      hz   = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
      run_br(kind, 3'($urandom), $urandom, $urandom, rs1, rs2, hz, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
